// File: rtl/vedic_mul_pipe_pkg.sv
// rtl/vedic_mul_pipe_pkg.sv - shared constants, stage bundle and width check for vedic_mul_pipe
// Purpose: pipeline depth, per-stage control bundle, power-of-two helper.
// Ports: none (package).
package vedic_pkg;

  localparam int PIPE_STAGES = 3;

  // Widest tag any instance may carry; the stage bundle is sized to this and
  // the top slices out TAG_W bits.
  localparam int MAX_TAG_W = 16;

  typedef struct packed {
    logic                 valid;
    logic                 sign;
    logic [MAX_TAG_W-1:0] tag;
  } stage_t;

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/vedic_mul_pipe_if.sv
// rtl/vedic_mul_pipe_if.sv - operand/result stream bundle for vedic_mul_pipe
// Purpose: groups the input and output valid/ready streams.
// Ports (signals): in_valid/in_ready/in_a/in_b/in_signed/in_tag,
//                  out_valid/out_ready/out_y/out_tag.
// Modports: master = operand issuer / result sink, slave = multiplier.
interface vedic_mul_pipe_if #(
  parameter int WIDTH = 64,
  parameter int TAG_W = 4
);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic               in_signed;
  logic [TAG_W-1:0]   in_tag;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_y;
  logic [TAG_W-1:0]   out_tag;

  modport master (
    output in_valid, in_a, in_b, in_signed, in_tag, out_ready,
    input  in_ready, out_valid, out_y, out_tag
  );

  modport slave (
    input  in_valid, in_a, in_b, in_signed, in_tag, out_ready,
    output in_ready, out_valid, out_y, out_tag
  );

endinterface

// File: rtl/vedic_nxn_comb.sv
// rtl/vedic_nxn_comb.sv - recursive combinational NxN Urdhva-Tiryagbhyam multiplier
// Purpose: unsigned N x N -> 2N product, split into four N/2 sub-products down to 2x2.
// Ports: a_i, b_i (N-bit operands), y_o (2N-bit product).
module vedic_nxn_comb #(
  parameter int N = 4
) (
  input  logic [N-1:0]   a_i,
  input  logic [N-1:0]   b_i,
  output logic [2*N-1:0] y_o
);

  generate
    if (N == 2) begin : g_base
      logic m1, m2, hh, c1;
      assign m1     = a_i[1] & b_i[0];
      assign m2     = a_i[0] & b_i[1];
      assign hh     = a_i[1] & b_i[1];
      assign c1     = m1 & m2;
      assign y_o[0] = a_i[0] & b_i[0];
      assign y_o[1] = m1 ^ m2;
      assign y_o[2] = hh ^ c1;
      assign y_o[3] = hh & c1;
    end else begin : g_rec
      localparam int M = N / 2;
      logic [N-1:0] ll, hh, lh, hl;

      vedic_nxn_comb #(.N(M)) u_ll (.a_i(a_i[M-1:0]), .b_i(b_i[M-1:0]), .y_o(ll));
      vedic_nxn_comb #(.N(M)) u_hh (.a_i(a_i[N-1:M]), .b_i(b_i[N-1:M]), .y_o(hh));
      vedic_nxn_comb #(.N(M)) u_lh (.a_i(a_i[M-1:0]), .b_i(b_i[N-1:M]), .y_o(lh));
      vedic_nxn_comb #(.N(M)) u_hl (.a_i(a_i[N-1:M]), .b_i(b_i[M-1:0]), .y_o(hl));

      // Cross products sit at offset M; the outer products tile the result.
      assign y_o = {hh, ll}
                 + {{M{1'b0}}, lh, {M{1'b0}}}
                 + {{M{1'b0}}, hl, {M{1'b0}}};
    end
  endgenerate

endmodule

// File: rtl/vedic_mul_pipe.sv
// rtl/vedic_mul_pipe.sv - three-stage pipelined Vedic multiplier with valid/ready streams
// Purpose: S1 sign/magnitude, S2 four half-width partial products, S3 CSA/RCA combine + negate.
// Ports: clk, rst (sync active-high), bus (vedic_mul_pipe_if.slave: operand and result streams).
module vedic_mul_pipe
  import vedic_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int TAG_W = 4
) (
  input  logic           clk,
  input  logic           rst,
  vedic_mul_pipe_if.slave bus
);

  localparam int H  = WIDTH / 2;
  localparam int W2 = 2 * WIDTH;

  generate
    if (!is_pow2(WIDTH) || WIDTH < 8 || WIDTH > 128) begin : g_bad_width
      $fatal(1, "vedic_mul_pipe: WIDTH must be a power of 2 in 8..128");
    end
    if (TAG_W < 1 || TAG_W > MAX_TAG_W) begin : g_bad_tag
      $fatal(1, "vedic_mul_pipe: TAG_W out of range");
    end
  endgenerate

  stage_t           s1_q, s1_d, s2_q;
  logic [WIDTH-1:0] mag_a_q, mag_b_q, mag_a_d, mag_b_d;
  logic [WIDTH-1:0] ll_q, hh_q, lh_q, hl_q, ll_d, hh_d, lh_d, hl_d;
  logic             out_valid_q;
  logic [W2-1:0]    out_y_q, y_d;
  logic [TAG_W-1:0] out_tag_q;

  // Valid bits and advance enables, indexed S1..S3 as 0..2. A stage may load
  // whenever it is empty or the stage after it is moving (bubble collapsing).
  logic [PIPE_STAGES-1:0] vld, adv;

  assign vld = {out_valid_q, s2_q.valid, s1_q.valid};

  always_comb begin
    adv = '0;
    adv[PIPE_STAGES-1] = !vld[PIPE_STAGES-1] || bus.out_ready;
    for (int k = PIPE_STAGES - 2; k >= 0; k--) begin
      adv[k] = !vld[k] || adv[k+1];
    end
  end

  assign bus.in_ready  = !rst && adv[0];
  assign bus.out_valid = out_valid_q;
  assign bus.out_y     = out_y_q;
  assign bus.out_tag   = out_tag_q;

  // S1: magnitudes. Negating -2^(W-1) wraps to 2^(W-1), which is the correct
  // unsigned magnitude.
  always_comb begin
    s1_d       = '0;
    s1_d.valid = bus.in_valid;
    s1_d.sign  = bus.in_signed && (bus.in_a[WIDTH-1] ^ bus.in_b[WIDTH-1]);
    s1_d.tag   = MAX_TAG_W'(bus.in_tag);
    mag_a_d    = (bus.in_signed && bus.in_a[WIDTH-1]) ? -bus.in_a : bus.in_a;
    mag_b_d    = (bus.in_signed && bus.in_b[WIDTH-1]) ? -bus.in_b : bus.in_b;
  end

  // S2: half-width partial products.
  vedic_nxn_comb #(.N(H)) u_ll (.a_i(mag_a_q[H-1:0]),     .b_i(mag_b_q[H-1:0]),     .y_o(ll_d));
  vedic_nxn_comb #(.N(H)) u_hh (.a_i(mag_a_q[WIDTH-1:H]), .b_i(mag_b_q[WIDTH-1:H]), .y_o(hh_d));
  vedic_nxn_comb #(.N(H)) u_lh (.a_i(mag_a_q[H-1:0]),     .b_i(mag_b_q[WIDTH-1:H]), .y_o(lh_d));
  vedic_nxn_comb #(.N(H)) u_hl (.a_i(mag_a_q[WIDTH-1:H]), .b_i(mag_b_q[H-1:0]),     .y_o(hl_d));

  // S3: the middle W bits (offset H) receive three addends; reduce them with
  // one carry-save level, resolve, and ripple the two carry-out bits into the
  // high half of hh.
  logic [WIDTH-1:0] x0, x1, x2, cs_s, cs_c;
  logic [WIDTH+1:0] mid;
  logic [H-1:0]     top;
  logic [W2-1:0]    mag_y;

  always_comb begin
    x0    = {hh_q[H-1:0], ll_q[WIDTH-1:H]};
    x1    = {hl_q[WIDTH-1:H], lh_q[H-1:0]};
    x2    = {lh_q[WIDTH-1:H], hl_q[H-1:0]};
    cs_s  = x0 ^ x1 ^ x2;
    cs_c  = (x0 & x1) | (x0 & x2) | (x1 & x2);
    mid   = {2'b00, cs_s} + {1'b0, cs_c, 1'b0};
    top   = hh_q[WIDTH-1:H] + {{(H-2){1'b0}}, mid[WIDTH+1:WIDTH]};
    mag_y = {top, mid[WIDTH-1:0], ll_q[H-1:0]};
    y_d   = s2_q.sign ? -mag_y : mag_y;
  end

  // Bundle bits above TAG_W are always zero and the S2 sign is consumed here.
  logic unused_s2_bits;
  assign unused_s2_bits = ^s2_q.tag;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q        <= '0;
      s2_q        <= '0;
      mag_a_q     <= '0;
      mag_b_q     <= '0;
      ll_q        <= '0;
      hh_q        <= '0;
      lh_q        <= '0;
      hl_q        <= '0;
      out_valid_q <= 1'b0;
      out_y_q     <= '0;
      out_tag_q   <= '0;
    end else begin
      if (adv[0]) begin
        s1_q    <= s1_d;
        mag_a_q <= mag_a_d;
        mag_b_q <= mag_b_d;
      end
      if (adv[1]) begin
        s2_q <= s1_q;
        ll_q <= ll_d;
        hh_q <= hh_d;
        lh_q <= lh_d;
        hl_q <= hl_d;
      end
      if (adv[2]) begin
        out_valid_q <= s2_q.valid;
        out_y_q     <= y_d;
        out_tag_q   <= s2_q.tag[TAG_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_vedic_mul_pipe.sv
// tb/tb_vedic_mul_pipe.sv - directed and scoreboarded bench for vedic_mul_pipe
module tb_vedic_mul_pipe;

  localparam int W  = 64;
  localparam int TW = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  vedic_mul_pipe_if #(.WIDTH(W), .TAG_W(TW)) bus ();

  vedic_mul_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_out    = 0;

  typedef struct {
    logic [127:0]  y;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t exp_q[$];

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [127:0] golden(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    logic [127:0] ea, eb;
    ea = s ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    eb = s ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    return ea * eb;
  endfunction

  // Scoreboard: every accepted beat is predicted; whenever out_valid is high
  // the oldest prediction must be on the output (covers stall stability too).
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_out", 1, 0);
        end else begin
          check("sb_y", bus.out_y, exp_q[0].y);
          check("sb_tag", 128'(bus.out_tag), 128'(exp_q[0].tag));
          if (bus.out_ready) begin
            void'(exp_q.pop_front());
            n_out++;
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back('{y: golden(bus.in_a, bus.in_b, bus.in_signed), tag: bus.in_tag});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_rand();
    bus.in_a      = {$urandom(), $urandom()};
    bus.in_b      = {$urandom(), $urandom()};
    bus.in_signed = 1'($urandom_range(0, 1));
    bus.in_tag    = TW'($urandom_range(0, 15));
  endtask

  task automatic run_one(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input logic [TW-1:0] t, input logic [127:0] exp_y);
    int lat;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_signed = s;
    bus.in_tag    = t;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    check({nm, "_in_ready"}, 128'(bus.in_ready), 1);
    tick();
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 8) begin
      tick();
      lat++;
    end
    check({nm, "_latency"}, 128'(lat), 3);
    check({nm, "_y"}, bus.out_y, exp_y);
    check({nm, "_tag"}, 128'(bus.out_tag), 128'(t));
    tick();
  endtask

  initial begin
    int acc;
    int k;
    int n0;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_signed = 1'b0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b0;
    repeat (3) tick();
    check("rst_out_valid", 128'(bus.out_valid), 0);
    check("rst_out_y", bus.out_y, 0);
    check("rst_out_tag", 128'(bus.out_tag), 0);
    check("rst_in_ready", 128'(bus.in_ready), 0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 128'(bus.in_ready), 1);

    // Directed vectors
    run_one("u_max", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 4'd3,
            128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
    run_one("s_m1x5", 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 1'b1, 4'd5,
            128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFB);
    run_one("s_minsq", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 4'd7,
            128'h4000_0000_0000_0000_0000_0000_0000_0000);
    run_one("s_zero_neg", 64'd0, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1, 4'd1, 128'd0);
    run_one("s_min_x1", 64'h8000_0000_0000_0000, 64'd1, 1'b1, 4'd2,
            128'hFFFF_FFFF_FFFF_FFFF_8000_0000_0000_0000);
    run_one("u_min_x2", 64'h8000_0000_0000_0000, 64'd2, 1'b0, 4'd15,
            128'h0000_0000_0000_0001_0000_0000_0000_0000);

    // Streaming: 100 back-to-back beats
    n0 = n_out;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      drive_rand();
      bus.in_valid = 1'b1;
      #1;
      check("stream_in_ready", 128'(bus.in_ready), 1);
      tick();
    end
    bus.in_valid = 1'b0;
    repeat (3) tick();
    check("stream_count", 128'(n_out - n0), 100);
    check("stream_drained", 128'(exp_q.size()), 0);

    // Backpressure: out_ready low for 10 cycles with in_valid held
    n0 = n_out;
    bus.out_ready = 1'b0;
    k = 0;
    drive_rand();
    bus.in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      acc = int'(bus.in_ready);
      tick();
      if (acc != 0) begin
        k++;
        drive_rand();
      end
    end
    #1;
    check("bp_accepted", 128'(k), 3);
    check("bp_in_ready_low", 128'(bus.in_ready), 0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (5) tick();
    check("bp_drain_count", 128'(n_out - n0), 3);
    check("bp_drained", 128'(exp_q.size()), 0);

    // Bubble collapse: A, two idle cycles, B, then C while the output stalls
    bus.out_ready = 1'b0;
    drive_rand();
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (2) tick();
    drive_rand();
    bus.in_valid = 1'b1;
    #1;
    check("bubble_b_ready", 128'(bus.in_ready), 1);
    tick();
    bus.in_valid = 1'b0;
    tick();
    drive_rand();
    bus.in_valid = 1'b1;
    #1;
    check("bubble_c_ready", 128'(bus.in_ready), 1);
    check("bubble_out_valid", 128'(bus.out_valid), 1);
    tick();
    bus.in_valid = 1'b0;
    #1;
    check("bubble_full_not_ready", 128'(bus.in_ready), 0);
    bus.out_ready = 1'b1;
    repeat (5) tick();
    check("bubble_drained", 128'(exp_q.size()), 0);

    // Reset with three beats in flight
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_rand();
      bus.in_valid = 1'b1;
      #1;
      check("rstfill_in_ready", 128'(bus.in_ready), 1);
      tick();
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    check("midrst_out_valid", 128'(bus.out_valid), 0);
    check("midrst_out_y", bus.out_y, 0);
    check("midrst_out_tag", 128'(bus.out_tag), 0);
    check("midrst_in_ready", 128'(bus.in_ready), 0);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("post_rst_no_stale", 128'(bus.out_valid), 0);
    end
    run_one("fresh_7x9", 64'd7, 64'd9, 1'b0, 4'd9, 128'd63);
    check("final_drained", 128'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/vedic_mul_pipe.md
Name: vedic_mul_pipe

Overview:
Parametrised, pipelined Vedic (Urdhva-Tiryagbhyam) multiplier with a valid/ready stream interface, per-transaction signed/unsigned mode and a pass-through tag. It is the streaming successor to the fixed 64x64 combinational multiplier. It sits between operand-issue logic and result writeback, sustaining one product per clock when unstalled.

Parameters:
- WIDTH, 64, operand width. Power of 2, 8..128. Product is 2*WIDTH bits.
- TAG_W, 4, width of the sideband tag carried alongside each operation.

Ports:
- clk, input, 1, clock. All logic is on the rising edge.
- rst, input, 1, synchronous, active-high reset.
- in_valid, input, 1, operand beat is valid.
- in_ready, output, 1, block accepts the beat this cycle.
- in_a, input, WIDTH, multiplicand.
- in_b, input, WIDTH, multiplier.
- in_signed, input, 1, 1 = two's-complement operands, 0 = unsigned.
- in_tag, input, TAG_W, sideband tag, returned unchanged with the result.
- out_valid, output, 1, result beat is valid.
- out_ready, input, 1, downstream accepts the result.
- out_y, output, 2*WIDTH, product.
- out_tag, output, TAG_W, tag of this product.

Behaviour:
- Transfers:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Three register stages, each holding a valid bit:
  - S1: registers the magnitudes of a and b, the product sign and the tag.
    - If in_signed, magnitude = two's-complement absolute value; sign = a[W-1]^b[W-1].
    - If unsigned, operands pass through and sign = 0.
  - S2: registers four (WIDTH/2)-bit partial products: lo*lo, hi*hi, lo*hi, hi*lo.
  - S3: combines the partial products as in the 64x64 block: a three-operand carry-save add of {hh[low half], ll[high half]}, {hl[high], lh[low]} and {lh[high], hl[low]}, then a ripple add of the carry into the hh high half. If sign is set, the result is negated (two's complement over 2*WIDTH). The result is registered into out_y/out_tag.
- Latency: exactly 3 cycles from input transfer to out_valid with no stall. Throughput is 1 per cycle.
- Flow control, with bubble collapsing:
  - stage_k advances when !valid_k || ready_{k+1}.
  - ready_out = out_ready.
  - in_ready = !valid_S1 || S1 advance. It is combinational from out_ready through the valid bits. There is no combinational path from in_valid to in_ready.
- Stalled stages hold their data and valid bits unchanged.
- out_y and out_tag are stable while out_valid && !out_ready.
- Signed edge cases:
  - -2^(W-1) has magnitude 2^(W-1), representable as W-bit unsigned.
  - (-2^(W-1))^2 = 2^(2W-2) must be exact.
  - A zero product with sign set must yield 0, not -0 artifacts. Negation of 0 gives 0 naturally.
- Simultaneous events: when the pipe is full, output transfer and input transfer occur in the same cycle, and all stages shift.
- Reset:
  - While rst is high: all valid bits clear, out_valid = 0, out_y = 0, out_tag = 0, in_ready = 0.
  - In-flight operations are discarded with no partial output.
  - in_ready rises in the first cycle after rst deasserts.
- Ordering: results emerge in strict input order. There is no reordering and no drop.

Decomposition:
- Package vedic_pkg:
  - constant PIPE_STAGES = 3
  - function is_pow2() for an elaboration check; WIDTH that is not a power of 2 or is outside 8..128 is a fatal elaboration error.
  - typedef of the stage bundle {valid, sign, tag}.
- Sub-module vedic_nxn_comb #(N): purely combinational, recursive NxN Vedic multiplier. The base case is 2x2. It is instantiated four times at N = WIDTH/2 in S2.
- Top level: stage registers, sign handling, CSA/RCA combine and handshake.

Test Plan:
- Unsigned, WIDTH=64:
  - a=0xFFFF_FFFF_FFFF_FFFF, b=0xFFFF_FFFF_FFFF_FFFF, tag=3 -> out_y=0xFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, out_tag=3, exactly 3 cycles after acceptance.
- Signed:
  - a=-1, b=5 -> out_y=-5, i.e. all-ones except low nibble 0xB.
  - a=b=0x8000_0000_0000_0000 -> out_y=2^126 (0x4000...0).
- Streaming: 100 back-to-back random beats with out_ready=1 and a mixed signed flag -> in_ready stays 1. Results match the golden model in order, 1 per cycle.
- Backpressure:
  - Hold out_ready=0 for 10 cycles with in_valid=1 -> exactly 3 beats accepted, then in_ready=0. out_y is stable throughout.
  - Release -> beats drain in order with no loss or duplication.
- Bubble collapse: issue beat, 2 idle cycles, then beat, while out_ready=0 -> both beats are held in S3/S2 and in_ready=1 for the third beat.
- Reset mid-stream: assert rst with 3 beats in flight -> the next cycle has out_valid=0 and out_y=0. No stale result appears after deassert. A fresh beat 7*9 returns 63.
